// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and widths for the register-file writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_bypass.sv
`default_nettype none
// ============================================================================
// Module      : wb_bypass
// Description : Registered compare of the write port against one read address.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bypass #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_ADDR_W-1:0] rs,
    output logic                  hit,
    output logic [XLEN-1:0]       data
);

    logic w_hit;

    // The register file returns the pre-write value for a same-edge read.
    assign w_hit = wen && (waddr == rs) && (rs != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            hit  <= 1'b0;
            data <= '0;
        end else begin
            hit  <= w_hit;
            data <= w_hit ? wdata : '0;
        end
    end

endmodule : wb_bypass
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Arbitrates ALU/LSU writeback onto the single register-file
//               write port and produces aligned bypass flags/data.
//               Define WB_RR_ARB_EN for round-robin instead of fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  wen,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [XLEN-1:0]       wdata,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  byp_rs1_hit,
    output logic [XLEN-1:0]       byp_rs1_data,
    output logic                  byp_rs2_hit,
    output logic [XLEN-1:0]       byp_rs2_data
);

    import wb_pkg::*;

    logic w_alu_win;
    logic w_lsu_win;

`ifdef WB_RR_ARB_EN
    wb_src_e r_last_grant;

    always_comb begin
        w_alu_win = alu_valid;
        if (alu_valid && lsu_valid) begin
            w_alu_win = (r_last_grant == WB_LSU);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= WB_ALU;
        end else if (alu_ready) begin
            r_last_grant <= WB_ALU;
        end else if (lsu_ready) begin
            r_last_grant <= WB_LSU;
        end
    end
`else
    localparam int                 c_CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

    logic [c_CNT_W-1:0] r_starve_cnt;

    assign w_alu_win = alu_valid && (!lsu_valid || (r_starve_cnt == c_STARVE_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (alu_valid && !alu_ready) begin
            if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end
`endif

    assign w_lsu_win = lsu_valid && !w_alu_win;
    assign alu_ready = !reset && w_alu_win;
    assign lsu_ready = !reset && w_lsu_win;

    // x0 requests are consumed like any other but never reach the array.
    always_comb begin
        wen   = 1'b0;
        waddr = '0;
        wdata = '0;
        if (alu_ready) begin
            wen   = (alu_rd != '0);
            waddr = alu_rd;
            wdata = alu_data;
        end else if (lsu_ready) begin
            wen   = (lsu_rd != '0);
            waddr = lsu_rd;
            wdata = lsu_data;
        end
    end

    wb_bypass #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_byp_rs1 (
        .clk   (clk),
        .reset (reset),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .rs    (rs1),
        .hit   (byp_rs1_hit),
        .data  (byp_rs1_data)
    );

    wb_bypass #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_byp_rs2 (
        .clk   (clk),
        .reset (reset),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .rs    (rs2),
        .hit   (byp_rs2_hit),
        .data  (byp_rs2_data)
    );

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    logic                  clk;
    logic                  reset;
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [REG_ADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0]       lsu_data;
    logic                  wen;
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  byp_rs1_hit;
    logic [XLEN-1:0]       byp_rs1_data;
    logic                  byp_rs2_hit;
    logic [XLEN-1:0]       byp_rs2_data;

    int n_cmp;
    int n_bad;

    regfile_wb_arbiter #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W),
        .STARVE_MAX (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .rs1          (rs1),
        .rs2          (rs2),
        .byp_rs1_hit  (byp_rs1_hit),
        .byp_rs1_data (byp_rs1_data),
        .byp_rs2_hit  (byp_rs2_hit),
        .byp_rs2_data (byp_rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after posedge; outputs are checked 2ns after posedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        rs1 = '0; rs2 = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2;
        #1;
        n_cmp++;
        if ({alu_ready, lsu_ready, wen} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ready_wen: got %b expected 000", {alu_ready, lsu_ready, wen});
        end
        n_cmp++;
        if ({byp_rs1_hit, byp_rs2_hit, byp_rs1_data, byp_rs2_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_bypass: got %b/%b %h/%h expected zeros",
                     byp_rs1_hit, byp_rs2_hit, byp_rs1_data, byp_rs2_data);
        end
        next_cycle();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({lsu_ready, alu_ready, wen, waddr, wdata} !== {1'b1, 1'b0, 1'b1, 5'd2, 32'hB2}) begin
            n_bad++;
            $display("FAIL post_reset_lsu_first: got lsu_rdy=%b alu_rdy=%b wen=%b waddr=%0d wdata=%h expected 1 0 1 2 b2",
                     lsu_ready, alu_ready, wen, waddr, wdata);
        end
        next_cycle();
        lsu_valid = 1'b0;
        #1;
        n_cmp++;
        if ({alu_ready, lsu_ready, waddr, wdata} !== {1'b1, 1'b0, 5'd1, 32'hA1}) begin
            n_bad++;
            $display("FAIL post_reset_alu_next: got alu_rdy=%b lsu_rdy=%b waddr=%0d wdata=%h expected 1 0 1 a1",
                     alu_ready, lsu_ready, waddr, wdata);
        end
        next_cycle();
        idle_inputs();
        #1;
        n_cmp++;
        if ({alu_ready, lsu_ready, wen, waddr, wdata} !== '0) begin
            n_bad++;
            $display("FAIL idle_port: got %b %b %b %0d %h expected all zero",
                     alu_ready, lsu_ready, wen, waddr, wdata);
        end
    endtask

    task automatic test_alu_alone();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if ({alu_ready, lsu_ready, wen, waddr, wdata} !== {1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL alu_alone: got rdy=%b lsu_rdy=%b wen=%b waddr=%0d wdata=%h expected 1 0 1 5 deadbeef",
                     alu_ready, lsu_ready, wen, waddr, wdata);
        end
        next_cycle();
        idle_inputs();
    endtask

`ifdef WB_RR_ARB_EN
    task automatic test_round_robin();
        logic exp_lsu;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
        lsu_valid = 1'b1; lsu_rd = 5'd3;
        for (int i = 0; i < 4; i++) begin
            lsu_data = 32'h11 + i;
            exp_lsu  = (i % 2 == 0);
            #1;
            n_cmp++;
            if ({lsu_ready, alu_ready} !== {exp_lsu, !exp_lsu}) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got lsu=%b alu=%b expected lsu=%b alu=%b",
                         i, lsu_ready, alu_ready, exp_lsu, !exp_lsu);
            end
            next_cycle();
        end
        idle_inputs();
    endtask
`else
    task automatic test_starvation();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
        lsu_valid = 1'b1; lsu_rd = 5'd3;
        for (int i = 0; i < 5; i++) begin
            logic            exp_alu;
            logic [4:0]      exp_addr;
            logic [XLEN-1:0] exp_data;
            lsu_data = 32'h11 + i;
            exp_alu  = (i == 3);
            exp_addr = exp_alu ? 5'd4 : 5'd3;
            exp_data = exp_alu ? 32'h22 : (32'h11 + i);
            #1;
            n_cmp++;
            if ({alu_ready, lsu_ready, waddr, wdata} !== {exp_alu, !exp_alu, exp_addr, exp_data}) begin
                n_bad++;
                $display("FAIL starve_grant[%0d]: got alu=%b lsu=%b waddr=%0d wdata=%h expected alu=%b lsu=%b waddr=%0d wdata=%h",
                         i, alu_ready, lsu_ready, waddr, wdata, exp_alu, !exp_alu, exp_addr, exp_data);
            end
            next_cycle();
        end
        idle_inputs();
    endtask
`endif

    task automatic test_x0_write();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
        rs1 = 5'd0; rs2 = 5'd0;
        #1;
        n_cmp++;
        if ({lsu_ready, wen} !== 2'b10) begin
            n_bad++;
            $display("FAIL x0_accept: got lsu_rdy=%b wen=%b expected 1 0", lsu_ready, wen);
        end
        next_cycle();
        idle_inputs();
        #1;
        n_cmp++;
        if ({byp_rs1_hit, byp_rs2_hit, byp_rs1_data, byp_rs2_data} !== '0) begin
            n_bad++;
            $display("FAIL x0_bypass: got %b/%b %h/%h expected zeros",
                     byp_rs1_hit, byp_rs2_hit, byp_rs1_data, byp_rs2_data);
        end
    endtask

    task automatic test_bypass();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hCAFE;
        rs1 = 5'd7; rs2 = 5'd8;
        next_cycle();
        idle_inputs();
        #1;
        n_cmp++;
        if ({byp_rs1_hit, byp_rs1_data, byp_rs2_hit, byp_rs2_data} !== {1'b1, 32'hCAFE, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL bypass_rs1: got hit1=%b d1=%h hit2=%b d2=%h expected 1 cafe 0 0",
                     byp_rs1_hit, byp_rs1_data, byp_rs2_hit, byp_rs2_data);
        end
        next_cycle();
        #1;
        n_cmp++;
        if ({byp_rs1_hit, byp_rs1_data} !== {1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL bypass_clear: got hit1=%b d1=%h expected 0 0", byp_rs1_hit, byp_rs1_data);
        end
    endtask

    task automatic test_back_to_back();
        // Same rd from both: LSU lands first, ALU follows with the final value.
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h2222;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h1111;
        rs1 = 5'd9; rs2 = 5'd6;
        #1;
        n_cmp++;
        if ({lsu_ready, wen, waddr, wdata} !== {1'b1, 1'b1, 5'd6, 32'h1111}) begin
            n_bad++;
            $display("FAIL b2b_first: got lsu_rdy=%b wen=%b waddr=%0d wdata=%h expected 1 1 6 1111",
                     lsu_ready, wen, waddr, wdata);
        end
        next_cycle();
        lsu_valid = 1'b0;
        #1;
        n_cmp++;
        if ({byp_rs2_hit, byp_rs2_data, byp_rs1_hit} !== {1'b1, 32'h1111, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_byp_first: got hit2=%b d2=%h hit1=%b expected 1 1111 0",
                     byp_rs2_hit, byp_rs2_data, byp_rs1_hit);
        end
        n_cmp++;
        if ({alu_ready, wen, waddr, wdata} !== {1'b1, 1'b1, 5'd6, 32'h2222}) begin
            n_bad++;
            $display("FAIL b2b_second: got alu_rdy=%b wen=%b waddr=%0d wdata=%h expected 1 1 6 2222",
                     alu_ready, wen, waddr, wdata);
        end
        next_cycle();
        idle_inputs();
        #1;
        n_cmp++;
        if ({byp_rs2_hit, byp_rs2_data} !== {1'b1, 32'h2222}) begin
            n_bad++;
            $display("FAIL b2b_byp_second: got hit2=%b d2=%h expected 1 2222", byp_rs2_hit, byp_rs2_data);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_alu_alone();
`ifdef WB_RR_ARB_EN
        test_round_robin();
`else
        test_starvation();
`endif
        test_x0_write();
        test_bypass();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
